// File: rtl/hhk_pkg.sv
// Shared definitions for the hhk accumulate/unwind counter pair.
// State encoding and default datapath width live here so both blocks agree.
package hhk_pkg;

  localparam int HHK_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } hhk_state_t;

endpackage

// File: rtl/hhk_unwind.sv
// Recovers A = SUM - B by moving one unit per cycle out of res into cnt until cnt == B.
// Start/busy/done handshake; B > SUM is flagged as underflow without running.
module hhk_unwind
  import hhk_pkg::*;
#(
  parameter int W = HHK_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] part_in,
  output logic         busy,
  output logic         done,
  output logic         underflow,
  output logic [W-1:0] res,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE_W = W'(1);

  hhk_state_t   state_reg, state_next;
  logic [W-1:0] res_reg, res_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic [W-1:0] sum_q, sum_next;
  logic [W-1:0] part_q, part_next;
  logic         uf_reg, uf_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      res_reg   <= '0;
      cnt_reg   <= '0;
      sum_q     <= '0;
      part_q    <= '0;
      uf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      res_reg   <= res_next;
      cnt_reg   <= cnt_next;
      sum_q     <= sum_next;
      part_q    <= part_next;
      uf_reg    <= uf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    res_next   = res_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_q;
    part_next  = part_q;
    uf_next    = uf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          sum_next  = sum_in;
          part_next = part_in;
          res_next  = sum_in;
          cnt_next  = '0;
          // The upfront compare is what keeps res from ever decrementing past zero.
          if (part_in > sum_in) begin
            uf_next    = 1'b1;
            state_next = DONE;
          end else if (part_in == '0) begin
            uf_next    = 1'b0;
            state_next = DONE;
          end else begin
            uf_next    = 1'b0;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        res_next = res_reg - ONE_W;
        cnt_next = cnt_reg + ONE_W;
        if (cnt_next == part_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign underflow = uf_reg;
  assign res       = res_reg;
  assign cnt       = cnt_reg;

`ifndef SYNTHESIS
  logic done_prev;

  always @(posedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= done;
      if (busy) begin
        assert (({1'b0, res_reg} + {1'b0, cnt_reg}) == {1'b0, sum_q})
          else $error("P1 res+cnt drifted from sum_q");
        assert (!done) else $error("P4 busy and done together");
      end
      if (done && !uf_reg) begin
        assert (res_reg == sum_q - part_q && cnt_reg == part_q)
          else $error("P2 wrong result at done");
      end
      if (done && uf_reg) begin
        assert (part_q > sum_q && cnt_reg == '0)
          else $error("P3 inconsistent underflow at done");
      end
      assert (!(done && done_prev)) else $error("P4 done longer than one cycle");
    end
  end
`endif

endmodule

// File: tb/tb_hhk_unwind.sv
// Directed bench for hhk_unwind: hand-computed results, latency, busy length and reset abort.
module tb_hhk_unwind;

  localparam int W = 17;
  localparam int LIMIT = 1000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] sum_in;
  logic [W-1:0] part_in;
  logic         busy;
  logic         done;
  logic         underflow;
  logic [W-1:0] res;
  logic [W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  hhk_unwind #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum_in    (sum_in),
    .part_in   (part_in),
    .busy      (busy),
    .done      (done),
    .underflow (underflow),
    .res       (res),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction: start at a falling edge, then watch every falling edge until done.
  // ign_at > 0 drives a second (ignored) start with sum=7 part=3 at that RUN cycle.
  task automatic run(input string tag, input logic [W-1:0] s, input logic [W-1:0] p,
                     input int ign_at, input int lat_e, input int busy_e,
                     input logic [W-1:0] res_e, input logic [W-1:0] cnt_e, input logic uf_e);
    int  lat;
    int  bcnt;
    bit  seen;
    @(negedge clk);
    start   = 1'b1;
    sum_in  = s;
    part_in = p;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    seen  = 1'b0;
    while (!seen && lat <= LIMIT) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) bcnt++;
        if (busy && ign_at > 0 && bcnt == ign_at) begin
          start   = 1'b1;
          sum_in  = 7;
          part_in = 3;
        end else begin
          start = 1'b0;
        end
        lat++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    $display("run %s: sum=%0d part=%0d latency=%0d busy=%0d res=%0d cnt=%0d uf=%0b",
             tag, s, p, lat, bcnt, res, cnt, underflow);
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, lat, lat_e);
    check({tag, "_busy_cycles"}, bcnt, busy_e);
    check({tag, "_res"}, {15'd0, res}, {15'd0, res_e});
    check({tag, "_cnt"}, {15'd0, cnt}, {15'd0, cnt_e});
    check({tag, "_underflow"}, {31'd0, underflow}, {31'd0, uf_e});
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_res_hold"}, {15'd0, res}, {15'd0, res_e});
    check({tag, "_uf_hold"}, {31'd0, underflow}, {31'd0, uf_e});
  endtask

  initial begin
    int  bcnt;
    bit  done_seen;

    rst     = 1'b1;
    start   = 1'b0;
    sum_in  = '0;
    part_in = '0;

    // T1: reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("reset: res=%0d cnt=%0d busy=%0b done=%0b uf=%0b", res, cnt, busy, done, underflow);
    check("t1_res", {15'd0, res}, 32'd0);
    check("t1_cnt", {15'd0, cnt}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd0);
    check("t1_underflow", {31'd0, underflow}, 32'd0);
    rst = 1'b0;

    // T2..T5: latency B+1 (1 for B==0 or underflow), busy for B cycles
    run("t2",  17'd500, 17'd200, 0, 201, 200, 17'd300, 17'd200, 1'b0);
    run("t3",  17'd300, 17'd0,   0, 1,   0,   17'd300, 17'd0,   1'b0);
    run("t4a", 17'd100, 17'd101, 0, 1,   0,   17'd100, 17'd0,   1'b1);
    run("t4b", 17'd100, 17'd100, 0, 101, 100, 17'd0,   17'd100, 1'b0);
    run("t5",  17'd50,  17'd10,  4, 11,  10,  17'd40,  17'd10,  1'b0);

    // T6: full-width boundaries (max SUM, off-by-one underflow)
    run("t6a", 17'd131071, 17'd5,      0, 6, 5, 17'd131066, 17'd5, 1'b0);
    run("t6b", 17'd131070, 17'd131071, 0, 1, 0, 17'd131070, 17'd0, 1'b1);
    run("t6c", 17'd1,      17'd1,      0, 2, 1, 17'd0,      17'd1, 1'b0);

    // T6 reset abort at RUN cycle 5
    @(negedge clk);
    start   = 1'b1;
    sum_in  = 17'd50;
    part_in = 17'd20;
    @(negedge clk);
    start = 1'b0;
    bcnt  = 0;
    for (int i = 0; i < LIMIT && bcnt < 5; i++) begin
      if (busy) bcnt++;
      if (bcnt < 5) @(negedge clk);
    end
    check("t6r_reached_run5", bcnt, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset abort: res=%0d cnt=%0d busy=%0b done=%0b uf=%0b", res, cnt, busy, done, underflow);
    check("t6r_res", {15'd0, res}, 32'd0);
    check("t6r_cnt", {15'd0, cnt}, 32'd0);
    check("t6r_busy", {31'd0, busy}, 32'd0);
    check("t6r_done", {31'd0, done}, 32'd0);
    check("t6r_underflow", {31'd0, underflow}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("t6r_no_done_after_abort", {31'd0, done_seen}, 32'd0);

    // A fresh run after the abort must still work
    run("t7", 17'd9, 17'd4, 0, 5, 4, 17'd5, 17'd4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
